parity_arbiter: RTL

Round-robin arbiter that shares one 16-bit parity generator between N requesters. Each requester offers a 16-bit word with a valid/ready handshake. The arbiter grants one requester at a time, registers the even parity (XOR of all bits) of that word, and returns it on a single response channel tagged with the requester index. It sits between the per-lane producers and the single parity_generator datapath instance.

---
 rtl/parity_pkg.sv | 10 +
 rtl/parity_generator.sv | 9 +
 rtl/parity_arbiter.sv | 102 ++++++++++
 3 files changed

// File: rtl/parity_pkg.sv
// Shared types and constants for the parity arbiter slice.
package parity_pkg;
  localparam int PARITY_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } arb_state_t;
endpackage

// File: rtl/parity_generator.sv
// Single shared parity datapath: even parity (XOR reduction) of one word.
module parity_generator
  import parity_pkg::*;
(
  input  logic [PARITY_W-1:0] data,
  output logic                parity
);
  assign parity = ^data;
endmodule

// File: rtl/parity_arbiter.sv
// Round-robin arbiter sharing one parity_generator between N requesters.
// Optional per-requester saturating grant counters under PARITY_ARB_STATS_EN.
module parity_arbiter
  import parity_pkg::*;
#(
  parameter int N   = 4,
  parameter int W   = PARITY_W,
  parameter int IDW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req_valid,
  input  logic [N*W-1:0] req_data,
  output logic [N-1:0]   req_ready,
  output logic           rsp_valid,
  output logic [IDW-1:0] rsp_id,
  output logic           rsp_parity,
  input  logic           rsp_ready
`ifdef PARITY_ARB_STATS_EN
  ,
  output logic [N*8-1:0] grant_cnt
`endif
);

  arb_state_t     state_q, state_d;
  logic [IDW-1:0] ptr_q, id_q, grant;
  logic [W-1:0]   data_q;
  logic           par_q, par_w, any, accept;

  // First set bit at or above p, wrapping modulo N.
  function automatic logic [IDW-1:0] rr_pick(input logic [N-1:0] v, input logic [IDW-1:0] p);
    logic [IDW-1:0] g;
    g = p;
    for (int k = N-1; k >= 0; k--) begin
      int j;
      j = (int'(p) + k) % N;
      if (v[j]) g = IDW'(j);
    end
    return g;
  endfunction

  assign any    = |req_valid;
  assign grant  = rr_pick(req_valid, ptr_q);
  assign accept = (state_q == IDLE) && any && !rst;

  parity_generator u_par (
    .data   (data_q),
    .parity (par_w)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any) state_d = CALC;
      CALC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are forced quiet while rst is high so a reset cycle never accepts or responds.
  always_comb begin
    for (int i = 0; i < N; i++) req_ready[i] = accept && (int'(grant) == i);
    rsp_valid  = (state_q == RESP) && !rst;
    rsp_id     = rst ? '0 : id_q;
    rsp_parity = !rst && par_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q  <= '0;
      data_q <= '0;
      id_q   <= '0;
      par_q  <= 1'b0;
    end else begin
      if (accept) begin
        data_q <= req_data[grant*W +: W];
        id_q   <= grant;
      end
      if (state_q == CALC) par_q <= par_w;
      if (state_q == RESP && rsp_ready)
        ptr_q <= (id_q == IDW'(N-1)) ? '0 : id_q + 1'b1;
    end
  end

`ifdef PARITY_ARB_STATS_EN
  for (genvar i = 0; i < N; i++) begin : g_cnt
    logic [7:0] cnt_q;
    always_ff @(posedge clk) begin
      if (rst)                               cnt_q <= '0;
      else if (req_ready[i] && cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
    end
    assign grant_cnt[i*8 +: 8] = cnt_q;
  end
`endif

endmodule
